rr_arbiter_hold: RTL and testbench

//  N-way round-robin arbiter with registered one-hot grant and multi-cycle grant hold.
//  The owner keeps the grant while its req stays high. The grant is force-rotated after
//  MAX_HOLD cycles when other requesters are waiting, unless the owner asserts lock.

---
 rtl/rr_arbiter_hold.sv | 136 +++++++++++++
 tb/tb_rr_arbiter_hold.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with registered one-hot grant, multi-cycle hold,
// forced rotation after MAX_HOLD cycles under contention, and an owner lock.
module rr_arbiter_hold #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_an,
    input  logic [N-1:0]   req,
    input  logic           lock,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           preempt
);

    localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_SAT = (MAX_HOLD == 0) ? HCW'(1) : HCW'(MAX_HOLD);
    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]     state_q,     state_d;
    logic [N-1:0]   gnt_q,       gnt_d;
    logic [IDW-1:0] gnt_id_q,    gnt_id_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic           preempt_q,   preempt_d;
    logic [IDW-1:0] ptr_q,       ptr_d;
    logic [HCW-1:0] hold_cnt_q,  hold_cnt_d;

    logic [N-1:0]   others;
    logic [N-1:0]   cand;
    logic           do_grant;
    logic [IDW-1:0] win;

    // First set bit of cand scanning start, start+1, ... with wrap-around.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] c, input logic [IDW-1:0] start);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(start) + i) % N;
            if (!found && c[idx]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        others     = req & ~gnt_q;
        cand       = req;
        do_grant   = 1'b0;
        win        = '0;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                    cand     = req;
                end
            end
            S_GRANT: begin
                if (!req[gnt_id_q]) begin
                    // Owner released: hand over directly without an idle bubble.
                    if (|others) begin
                        do_grant = 1'b1;
                        cand     = others;
                    end else begin
                        gnt_d      = '0;
                        hold_cnt_d = '0;
                        state_d    = S_IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_SAT) && !lock && (|others)) begin
                    do_grant  = 1'b1;
                    cand      = others;
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        if (do_grant) begin
            win        = pick(cand, ptr_q);
            gnt_d      = ONE_HOT0 << win;
            gnt_id_d   = win;
            ptr_d      = IDW'((int'(win) + 1) % N);
            hold_cnt_d = HCW'(1);
            state_d    = S_GRANT;
        end

        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: directed vectors, an integer-level reference
// model compared every cycle, and hand-computed literal expectations.
module tb_rr_arbiter_hold;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = $clog2(N);

    logic           clk;
    logic           rst_an;
    logic [N-1:0]   req;
    logic           lock;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           preempt;

    int checks;
    int errors;

    // Reference model: owner index (-1 when idle), rotating pointer, hold length.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    rr_arbiter_hold #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_an    (rst_an),
        .req       (req),
        .lock      (lock),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] c, input int start);
        for (int i = 0; i < N; i++) begin
            if (c[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] others_of(input logic [N-1:0] r, input int owner);
        logic [N-1:0] m;
        m        = '0;
        m[owner] = 1'b1;
        return r & ~m;
    endfunction

    always @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_hold  <= 0;
            m_pre   <= 1'b0;
        end else if (m_owner < 0) begin
            m_pre <= 1'b0;
            if (req != '0) begin
                m_owner <= rr_pick(req, m_ptr);
                m_ptr   <= (rr_pick(req, m_ptr) + 1) % N;
                m_hold  <= 1;
            end
        end else if (!req[m_owner]) begin
            m_pre <= 1'b0;
            if (others_of(req, m_owner) != '0) begin
                m_owner <= rr_pick(others_of(req, m_owner), m_ptr);
                m_ptr   <= (rr_pick(others_of(req, m_owner), m_ptr) + 1) % N;
                m_hold  <= 1;
            end else begin
                m_owner <= -1;
                m_hold  <= 0;
            end
        end else if (m_hold >= MAX_HOLD && !lock && others_of(req, m_owner) != '0) begin
            m_owner <= rr_pick(others_of(req, m_owner), m_ptr);
            m_ptr   <= (rr_pick(others_of(req, m_owner), m_ptr) + 1) % N;
            m_hold  <= 1;
            m_pre   <= 1'b1;
        end else begin
            m_pre <= 1'b0;
            if (m_hold < MAX_HOLD) m_hold <= m_hold + 1;
        end
    end

    // Compare DUT outputs against the model.
    task automatic compareModel();
        logic [N-1:0] exp_gnt;
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        checks++;
        if (gnt !== exp_gnt) begin
            errors++;
            $display("[TB] FAIL model_gnt t=%0t: gnt=%b expected %b", $time, gnt, exp_gnt);
        end
        checks++;
        if (gnt_valid !== (m_owner >= 0)) begin
            errors++;
            $display("[TB] FAIL model_valid t=%0t: gnt_valid=%b expected %b", $time, gnt_valid, (m_owner >= 0));
        end
        checks++;
        if (preempt !== m_pre) begin
            errors++;
            $display("[TB] FAIL model_preempt t=%0t: preempt=%b expected %b", $time, preempt, m_pre);
        end
        if (m_owner >= 0) begin
            checks++;
            if (int'(gnt_id) != m_owner) begin
                errors++;
                $display("[TB] FAIL model_gnt_id t=%0t: gnt_id=%0d expected %0d", $time, gnt_id, m_owner);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            compareModel();
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic l);
        req  = r;
        lock = l;
    endtask

    // Literal expectation, independent of the model.
    task automatic checkOutput(input string name, input logic [N-1:0] exp_gnt, input logic exp_pre);
        int exp_id;
        exp_id = 0;
        for (int i = 0; i < N; i++) if (exp_gnt[i]) exp_id = i;
        checks++;
        if (gnt !== exp_gnt || gnt_valid !== (|exp_gnt) || preempt !== exp_pre) begin
            errors++;
            $display("[TB] FAIL %s: gnt=%b valid=%b preempt=%b expected gnt=%b valid=%b preempt=%b",
                     name, gnt, gnt_valid, preempt, exp_gnt, |exp_gnt, exp_pre);
        end
        if (|exp_gnt) begin
            checks++;
            if (int'(gnt_id) != exp_id) begin
                errors++;
                $display("[TB] FAIL %s_id: gnt_id=%0d expected %0d", name, gnt_id, exp_id);
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] r;
        logic         l;
        int           cycles;
    } vec_t;

    vec_t vecs[8];

    initial begin
        checks = 0;
        errors = 0;
        rst_an = 1'b0;
        applyStimulus(4'b1111, 1'b0);

        // Reset with all requests up, release between edges.
        tick(2);
        checkOutput("reset_state", 4'b0000, 1'b0);
        rst_an = 1'b1;
        #1;
        checkOutput("no_grant_before_edge", 4'b0000, 1'b0);
        tick(1);
        checkOutput("first_grant", 4'b0001, 1'b0);

        // Full contention: each grant lasts exactly MAX_HOLD cycles.
        tick(7);
        checkOutput("hold0_last_cycle", 4'b0001, 1'b0);
        tick(1);
        checkOutput("rotate_to_1", 4'b0010, 1'b1);
        tick(1);
        checkOutput("preempt_one_cycle", 4'b0010, 1'b0);
        tick(6);
        checkOutput("hold1_last_cycle", 4'b0010, 1'b0);
        tick(1);
        checkOutput("rotate_to_2", 4'b0100, 1'b1);
        tick(8);
        checkOutput("rotate_to_3", 4'b1000, 1'b1);
        tick(8);
        checkOutput("rotate_wrap_0", 4'b0001, 1'b1);

        // Release hands over without a bubble, then goes idle.
        rst_an = 1'b0;
        applyStimulus(4'b1010, 1'b0);
        tick(2);
        rst_an = 1'b1;
        tick(1);
        checkOutput("pick_1_of_1010", 4'b0010, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        tick(1);
        checkOutput("handover_no_bubble", 4'b1000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        tick(1);
        checkOutput("release_to_idle", 4'b0000, 1'b0);

        // Lock suppresses forced rotation; dropping it rotates at the next edge.
        rst_an = 1'b0;
        applyStimulus(4'b0011, 1'b1);
        tick(2);
        rst_an = 1'b1;
        tick(1);
        checkOutput("lock_first", 4'b0001, 1'b0);
        tick(19);
        checkOutput("lock_hold_20", 4'b0001, 1'b0);
        applyStimulus(4'b0011, 1'b0);
        tick(1);
        checkOutput("unlock_rotate", 4'b0010, 1'b1);

        // Wrap-around priority after a grant to the top index.
        applyStimulus(4'b1000, 1'b0);
        tick(1);
        checkOutput("grant_3", 4'b1000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        tick(1);
        checkOutput("idle_after_3", 4'b0000, 1'b0);
        applyStimulus(4'b1001, 1'b0);
        tick(1);
        checkOutput("wrap_ptr0", 4'b0001, 1'b0);
        applyStimulus(4'b1000, 1'b0);
        tick(1);
        checkOutput("wrap_then_3", 4'b1000, 1'b0);

        // Asynchronous reset mid-grant, then arbitration restarts from index 0.
        applyStimulus(4'b0010, 1'b0);
        tick(1);
        checkOutput("grant_1_ptr2", 4'b0010, 1'b0);
        applyStimulus(4'b1111, 1'b0);
        tick(2);
        checkOutput("keep_1", 4'b0010, 1'b0);
        #2;
        rst_an = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 1'b0);
        tick(1);
        rst_an = 1'b1;
        tick(1);
        checkOutput("ptr_reset", 4'b0001, 1'b0);

        // Mixed directed sequence, checked against the model every cycle.
        vecs[0] = '{4'b0110, 1'b0, 3};
        vecs[1] = '{4'b0100, 1'b0, 2};
        vecs[2] = '{4'b1101, 1'b1, 12};
        vecs[3] = '{4'b1101, 1'b0, 20};
        vecs[4] = '{4'b0000, 1'b1, 2};
        vecs[5] = '{4'b0001, 1'b1, 12};
        vecs[6] = '{4'b0111, 1'b0, 30};
        vecs[7] = '{4'b1010, 1'b0, 5};
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].r, vecs[v].l);
            tick(vecs[v].cycles);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
